// File: rtl/reg_file_wb_if.sv
// Bundle of register-file signals between the write-back/decode side (master)
// and the register file with its pending-write scoreboard (slave).
interface reg_file_wb_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
);
    logic [ADDR_W-1:0]   rs_addr;
    logic [ADDR_W-1:0]   rt_addr;
    logic                rs_used;
    logic                rt_used;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic                reg_write;
    logic [ADDR_W-1:0]   write_addr;
    logic [DATA_W-1:0]   write_reg_data;
    logic                pend_set;
    logic [ADDR_W-1:0]   pend_addr;
    logic                stall;
    logic [NUM_REGS-1:0] pending_mask;
    logic                hazard_err;

    modport master (
        output rs_addr, rt_addr, rs_used, rt_used,
        output reg_write, write_addr, write_reg_data,
        output pend_set, pend_addr,
        input  rs_data, rt_data, stall, pending_mask, hazard_err
    );

    modport slave (
        input  rs_addr, rt_addr, rs_used, rt_used,
        input  reg_write, write_addr, write_reg_data,
        input  pend_set, pend_addr,
        output rs_data, rt_data, stall, pending_mask, hazard_err
    );
endinterface

// File: rtl/reg_file_wb.sv
// 32x32 register file with write-back bypass on both read ports and a
// pending-write scoreboard that stalls decode on reads of in-flight results.
module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_wb_if.slave bus
);
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic                r_hazard_err;

    logic [NUM_REGS-1:0] w_wr_dec;
    logic [NUM_REGS-1:0] w_set_dec;
    logic [NUM_REGS-1:0] w_pending_next;
    logic [NUM_REGS-1:0] w_pend_eff;
    logic                w_double_issue;
    logic                w_overtake;
    logic                w_rs_bypass;
    logic                w_rt_bypass;

    // Per-register decode; register 0 never writes and never goes pending.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            if (gi == 0) begin : g_zero
                assign w_wr_dec[gi]  = 1'b0;
                assign w_set_dec[gi] = 1'b0;
            end else begin : g_nz
                assign w_wr_dec[gi]  = bus.reg_write && (bus.write_addr == ADDR_W'(gi));
                assign w_set_dec[gi] = bus.pend_set  && (bus.pend_addr  == ADDR_W'(gi));
            end
            // A new producer issued as the old one retires keeps the bit set.
            assign w_pending_next[gi] = w_set_dec[gi] | (r_pending[gi] & ~w_wr_dec[gi]);
            assign w_pend_eff[gi]     = r_pending[gi] & ~w_wr_dec[gi];
        end
    endgenerate

    assign w_double_issue = |(w_set_dec & r_pending & ~w_wr_dec);
    assign w_overtake     = |(w_set_dec & w_wr_dec & ~r_pending);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_dec[i]) begin
                    r_regs[i] <= bus.write_reg_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending    <= '0;
            r_hazard_err <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_hazard_err <= r_hazard_err | w_double_issue | w_overtake;
        end
    end

    assign w_rs_bypass = bus.reg_write && (bus.write_addr == bus.rs_addr);
    assign w_rt_bypass = bus.reg_write && (bus.write_addr == bus.rt_addr);

    always_comb begin
        bus.rs_data = r_regs[bus.rs_addr];
        if (bus.rs_addr == '0) begin
            bus.rs_data = '0;
        end else if (w_rs_bypass) begin
            bus.rs_data = bus.write_reg_data;
        end
    end

    always_comb begin
        bus.rt_data = r_regs[bus.rt_addr];
        if (bus.rt_addr == '0) begin
            bus.rt_data = '0;
        end else if (w_rt_bypass) begin
            bus.rt_data = bus.write_reg_data;
        end
    end

    // Bit 0 of w_pend_eff is constant 0, so address 0 never stalls.
    assign bus.stall = (bus.rs_used & w_pend_eff[bus.rs_addr])
                     | (bus.rt_used & w_pend_eff[bus.rt_addr]);

    assign bus.pending_mask = r_pending;
    assign bus.hazard_err   = r_hazard_err;
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed and randomized checks of reg_file_wb against an array-based
// model of register contents, pending bits and the sticky error flag.
module tb_reg_file_wb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_wb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) bus_if ();

    reg_file_wb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus_if.reg_write && bus_if.write_addr == a) return bus_if.write_reg_data;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a] && !(bus_if.reg_write && bus_if.write_addr == a);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = m_pend[i];
        return m;
    endfunction

    task automatic apply(input bit r, input bit rw, input logic [4:0] wa, input logic [31:0] wd,
                         input bit ps, input logic [4:0] pa, input logic [4:0] rsa,
                         input logic [4:0] rta, input bit rsu, input bit rtu);
        rst                   = r;
        bus_if.reg_write      = rw;
        bus_if.write_addr     = wa;
        bus_if.write_reg_data = wd;
        bus_if.pend_set       = ps;
        bus_if.pend_addr      = pa;
        bus_if.rs_addr        = rsa;
        bus_if.rt_addr        = rta;
        bus_if.rs_used        = rsu;
        bus_if.rt_used        = rtu;
        @(negedge clk);
    endtask

    task automatic check_model();
        logic exp_stall;
        exp_stall = (bus_if.rs_used && m_busy(bus_if.rs_addr)) ||
                    (bus_if.rt_used && m_busy(bus_if.rt_addr));
        check("rs_data", bus_if.rs_data, m_read(bus_if.rs_addr));
        check("rt_data", bus_if.rt_data, m_read(bus_if.rt_addr));
        check("stall", {31'b0, bus_if.stall}, {31'b0, exp_stall});
        check("pending_mask", bus_if.pending_mask, m_mask());
        check("hazard_err", {31'b0, bus_if.hazard_err}, {31'b0, m_err});
    endtask

    task automatic tick();
        bit ps_ok, wr_ok;
        logic [4:0] wa, pa;
        @(posedge clk);
        wa    = bus_if.write_addr;
        pa    = bus_if.pend_addr;
        ps_ok = bus_if.pend_set && pa != 5'd0;
        wr_ok = bus_if.reg_write && wa != 5'd0;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            if (ps_ok && m_pend[pa] && !(wr_ok && wa == pa)) m_err = 1'b1;
            if (ps_ok && wr_ok && wa == pa && !m_pend[pa]) m_err = 1'b1;
            if (wr_ok) begin
                m_regs[wa] = bus_if.write_reg_data;
                m_pend[wa] = 1'b0;
            end
            if (ps_ok) m_pend[pa] = 1'b1;
        end
        #1;
    endtask

    task automatic step(input bit r, input bit rw, input logic [4:0] wa, input logic [31:0] wd,
                        input bit ps, input logic [4:0] pa, input logic [4:0] rsa,
                        input logic [4:0] rta, input bit rsu, input bit rtu);
        apply(r, rw, wa, wd, ps, pa, rsa, rta, rsu, rtu);
        check_model();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;

        // Reset for two cycles, then sweep every address on both ports.
        apply(0, 1, 5'd3, 32'h55, 1, 5'd3, 0, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 32; i++) begin
            apply(1, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 1);
            check_model();
            check("reset_rs", bus_if.rs_data, 32'h0);
            tick();
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_mask", bus_if.pending_mask, 32'h0);
        check("reset_err", {31'b0, bus_if.hazard_err}, 32'h0);
        tick();

        // Write with same-cycle bypass, array read next cycle, r0 stays zero.
        apply(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 0, 1, 0);
        check_model();
        check("bypass_r5", bus_if.rs_data, 32'hDEADBEEF);
        tick();
        apply(1, 0, 0, 0, 0, 0, 5'd5, 5'd5, 0, 0);
        check_model();
        check("array_r5", bus_if.rt_data, 32'hDEADBEEF);
        tick();
        step(1, 1, 5'd0, 32'h1234, 0, 0, 5'd0, 5'd0, 1, 1);
        apply(1, 0, 0, 0, 0, 0, 5'd0, 5'd5, 0, 0);
        check_model();
        check("r0_zero", bus_if.rs_data, 32'h0);
        tick();

        // Load-use stall on r7, released by its own write-back.
        step(1, 0, 0, 0, 1, 5'd7, 0, 5'd7, 0, 1);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 5'd7, 0, 1);
            check_model();
            check("load_use_stall", {31'b0, bus_if.stall}, 32'h1);
            tick();
        end
        apply(1, 1, 5'd7, 32'hA5A5A5A5, 0, 0, 0, 5'd7, 0, 1);
        check_model();
        check("wb_release_stall", {31'b0, bus_if.stall}, 32'h0);
        check("wb_release_data", bus_if.rt_data, 32'hA5A5A5A5);
        tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pmask7_clear", {31'b0, bus_if.pending_mask[7]}, 32'h0);
        tick();

        // The used qualifier gates the stall.
        step(1, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 5'd9, 0, 0, 0);
        check("unused_no_stall", {31'b0, bus_if.stall}, 32'h0);
        tick();
        apply(1, 0, 0, 0, 0, 0, 5'd9, 0, 1, 0);
        check("used_stall", {31'b0, bus_if.stall}, 32'h1);
        tick();

        // Simultaneous retire and re-issue on r3: set wins, no error.
        step(1, 0, 0, 0, 1, 5'd3, 0, 0, 0, 0);
        step(1, 1, 5'd3, 32'h11, 1, 5'd3, 5'd3, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 5'd3, 0, 0, 0);
        check_model();
        check("setclr_mask3", {31'b0, bus_if.pending_mask[3]}, 32'h1);
        check("setclr_err", {31'b0, bus_if.hazard_err}, 32'h0);
        check("setclr_r3", bus_if.rs_data, 32'h11);
        tick();

        // Double producer on r4, then reset mid-flight.
        step(1, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("double_issue_err", {31'b0, bus_if.hazard_err}, 32'h1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 5'd4, 5'd7, 1, 1);
        check_model();
        check("rst_err", {31'b0, bus_if.hazard_err}, 32'h0);
        check("rst_mask", bus_if.pending_mask, 32'h0);
        check("rst_r4", bus_if.rs_data, 32'h0);
        tick();
        step(1, 1, 5'd4, 32'hCAFE, 0, 0, 5'd4, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("plain_write_no_err", {31'b0, bus_if.hazard_err}, 32'h0);
        tick();

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            bit r, rw, ps, rsu, rtu;
            logic [4:0] wa, pa, rsa, rta;
            r   = ($urandom_range(0, 59) != 0);
            rw  = 1'($urandom_range(0, 1));
            ps  = ($urandom_range(0, 3) == 0);
            wa  = 5'($urandom_range(0, 7));
            pa  = 5'($urandom_range(0, 7));
            rsa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rta = 5'($urandom_range(0, 7));
            rsu = 1'($urandom_range(0, 1));
            rtu = 1'($urandom_range(0, 1));
            step(r, rw, wa, $urandom, ps, pa, rsa, rta, rsu, rtu);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
